// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and its datapath.
// master: sequencer side (IR fields, zero, mem_ready in; selects, strobes, count out).
interface multi_cycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             iord;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_src;
  logic [2:0]       mod;
  logic             instr_done;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, iord, ir_write,
    output mem_read, mem_write,
    output reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, pc_src, mod,
    output instr_done, illegal, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, iord, ir_write,
    input  mem_read, mem_write,
    input  reg_dst, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, pc_src, mod,
    input  instr_done, illegal, retired
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset sequencer: FETCH/DECODE/EXEC/MEM/WB walk.
// Ports: clk, reset (async, active-low), bus (master: datapath controls).
module multi_cycle_ctrl #(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  multi_cycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB,
    MEMWR, EXEC, RWB, BRANCH, JUMP
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  state_t           state;
  logic [CNT_W-1:0] retired_q;
  logic             fn_ok;
  logic [2:0]       fn_mod;

  always_comb begin
    fn_ok  = 1'b1;
    fn_mod = 3'b011;
    case (bus.funct)
      6'b100000: fn_mod = 3'b010;
      6'b100010: fn_mod = 3'b110;
      6'b100100: fn_mod = 3'b000;
      6'b100101: fn_mod = 3'b001;
      6'b101010: fn_mod = 3'b111;
      default:   fn_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      retired_q <= '0;
    end else begin
      if (bus.instr_done)
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state)
        IDLE:   state <= FETCH;
        FETCH:  if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_R:         state <= EXEC;
            OP_LW, OP_SW: state <= MEMADR;
            OP_BEQ:       state <= BRANCH;
            OP_J:         state <= JUMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: state <= (bus.opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  if (bus.mem_ready) state <= MEMWB;
        MEMWR:  if (bus.mem_ready) state <= FETCH;
        EXEC:   state <= fn_ok ? RWB : FETCH;
        MEMWB, RWB, BRANCH, JUMP: state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.retired = retired_q;

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_src     = 2'b00;
    bus.mod        = 3'b000;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    unique case (state)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.mod       = 3'b010;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_b = 2'b10;
        bus.mod       = 3'b010;
        bus.illegal   = !(bus.opcode inside
          {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J});
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.mod       = 3'b010;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEMWR: begin
        bus.mem_write  = 1'b1;
        bus.iord       = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.mod       = fn_mod;
        bus.illegal   = !fn_ok;
      end
      RWB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a  = 1'b1;
        bus.mod        = 3'b110;
        bus.pc_src     = 2'b01;
        bus.pc_write   = bus.zero;
        bus.instr_done = 1'b1;
      end
      JUMP: begin
        bus.pc_src     = 2'b10;
        bus.pc_write   = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
